// File: rtl/bus_arbiter_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_loader_pkg
// Purpose : Shared types and default constants for the burst arbiter/loader.
//           Holds the arbiter FSM state encoding and the default geometry
//           (address width, data width, burst length, weight base address).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package bus_arbiter_loader_pkg;

  // Arbiter FSM states; the grant outputs decode straight from these.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IN = 2'd1,
    GNT_W  = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  localparam int DEF_ADD_WIDTH  = 6;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_W_BASE     = 16;

endpackage : bus_arbiter_loader_pkg
`default_nettype wire

// File: rtl/bus_arbiter_loader_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb_pick
// Purpose : Two-way request selector. With ROUND_ROBIN=0 the input channel
//           always wins a tie; with ROUND_ROBIN=1 a tie goes to the channel
//           that was not granted last (last_w=1 means weights went last).
// Ports   : req_in, req_w   - requests from the two channels
//           last_w          - last-granted channel was W (ignored when fixed)
//           pick_in, pick_w - one-hot (or zero) selection
// Rev     : 1.0  initial release
// ============================================================================
module arb_pick #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic req_in,
  input  logic req_w,
  input  logic last_w,
  output logic pick_in,
  output logic pick_w
);

  generate
    if (ROUND_ROBIN) begin : g_rr
      assign pick_in = req_in & (~req_w | last_w);
      assign pick_w  = req_w  & (~req_in | ~last_w);
    end else begin : g_fixed
      logic unused_last_w;
      assign unused_last_w = last_w;
      assign pick_in = req_in;
      assign pick_w  = req_w & ~req_in;
    end
  endgenerate

endmodule : arb_pick
`default_nettype wire

// File: rtl/bus_arbiter_loader.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter_loader
// Purpose : Arbitrates burst requests from an input channel and a weight
//           channel, then streams BURST_LEN words from the host stream into
//           RAM at base 0 (input) or W_BASE (weights). Flags stream underrun
//           and early request drop with sticky error bits.
// Config  : `define ARB_ROUND_ROBIN_EN -> ties alternate between channels
//           (input wins the first tie after reset); undefined -> input
//           always wins a tie and no last-granted state is kept.
// Ports   : clk, rst (async, active-high)
//           req_in, req_w        - burst requests
//           grant_in, grant_w    - registered grants (decoded from state)
//           src_valid, src_data  - upstream stream, src_ready pops a word
//           ram_we, ram_addr, ram_wdata - RAM write port
//           burst_done           - pulse the cycle after a complete burst
//           err_underrun, err_abort - sticky error flags
// Rev     : 1.0  initial release
// ============================================================================
module bus_arbiter_loader
  import bus_arbiter_loader_pkg::*;
#(
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int W_BASE     = DEF_W_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_in,
  input  logic                  req_w,
  output logic                  grant_in,
  output logic                  grant_w,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  ram_we,
  output logic [ADD_WIDTH:0]    ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  burst_done,
  output logic                  err_underrun,
  output logic                  err_abort
);

  localparam int                BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADD_WIDTH:0] W_BASE_ADDR = (ADD_WIDTH + 1)'(W_BASE);

  arb_state_t        state, state_next;
  logic [BEAT_W-1:0] beat;
  logic              in_grant;
  logic              match_req;
  logic              beat_valid;
  logic              last_beat;
  logic              pick_in, pick_w;
  logic              burst_done_r;
  logic              err_underrun_r, err_abort_r;
  logic              last_w;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;

  // Resets to W so that the first tie after reset goes to the input channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_w <= 1'b1;
    end else if (state == IDLE && state_next == GNT_IN) begin
      last_w <= 1'b0;
    end else if (state == IDLE && state_next == GNT_W) begin
      last_w <= 1'b1;
    end
  end
`else
  localparam bit RR_EN = 1'b0;
  assign last_w = 1'b0;
`endif

  arb_pick #(
    .ROUND_ROBIN (RR_EN)
  ) u_arb_pick (
    .req_in  (req_in),
    .req_w   (req_w),
    .last_w  (last_w),
    .pick_in (pick_in),
    .pick_w  (pick_w)
  );

  assign in_grant   = (state == GNT_IN) || (state == GNT_W);
  // Only the request of the granted channel matters; the other is ignored.
  assign match_req  = ((state == GNT_IN) && req_in) || ((state == GNT_W) && req_w);
  assign beat_valid = match_req;
  assign last_beat  = beat_valid && (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_in) begin
          state_next = GNT_IN;
        end else if (pick_w) begin
          state_next = GNT_W;
        end
      end
      GNT_IN, GNT_W: begin
        // Early drop and final beat both leave through the one-cycle GAP.
        if (!match_req || beat == LAST_BEAT) begin
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat counter is held at zero outside grant states, so it is clear on
  // entry; an underrun beat still advances it (the address is skipped).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (!in_grant) begin
      beat <= '0;
    end else if (beat_valid) begin
      beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_done_r   <= 1'b0;
      err_underrun_r <= 1'b0;
      err_abort_r    <= 1'b0;
    end else begin
      burst_done_r   <= last_beat;
      err_underrun_r <= err_underrun_r | (beat_valid & ~src_valid);
      err_abort_r    <= err_abort_r | (in_grant & ~match_req);
    end
  end

  assign grant_in     = (state == GNT_IN);
  assign grant_w      = (state == GNT_W);
  assign src_ready    = beat_valid;
  assign ram_we       = beat_valid & src_valid;
  assign ram_addr     = !in_grant         ? '0 :
                        (state == GNT_W)  ? W_BASE_ADDR + (ADD_WIDTH + 1)'(beat) :
                                            (ADD_WIDTH + 1)'(beat);
  assign ram_wdata    = beat_valid ? src_data : '0;
  assign burst_done   = burst_done_r;
  assign err_underrun = err_underrun_r;
  assign err_abort    = err_abort_r;

endmodule : bus_arbiter_loader
`default_nettype wire
